// File: rtl/addsub_share_ctrl.sv
// Round-robin sharing of one external ripple add/sub datapath between two requesters; optional {C,Z,N,V} flags with ADDSUB_SHARE_CTRL_FLAGS_EN.
// Latency: rsp_valid rises SETTLE cycles after the accept edge; one operation per SETTLE+2 cycles at best.
// Backpressure: a response is held, along with the datapath operands, until rsp_ready; no new accepts until it leaves.
module addsub_share_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
    ,
    output logic [3:0]       rsp_flags
`endif
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          prio_q;   // set when requester 1 wins a tie
    logic          id_q;
    op_t           op_q;
    op_t           req_sel;
    logic          gnt_vld;
    logic          gnt_id;
    logic          accept;
    logic          capture;
    logic          release_rsp;

    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = prio_q;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
        req_sel = gnt_id ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_vld) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CW'(1)) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Ready is combinational; masking with rst keeps every output low while reset is held.
    always_comb begin
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        busy        = 1'b1;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy       = 1'b0;
                accept     = gnt_vld & ~rst;
                req0_ready = accept & ~gnt_id;
                req1_ready = accept & gnt_id;
            end
            ST_SETTLE: capture     = (cnt_q == CW'(1));
            ST_RESP:   release_rsp = rsp_ready;
            default:   busy        = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            id_q   <= 1'b0;
            prio_q <= 1'b0;
        end else if (accept) begin
            op_q   <= req_sel;
            id_q   <= gnt_id;
            prio_q <= ~gnt_id;
            cnt_q  <= CW'(SETTLE);
        end else if (state_q == ST_SETTLE) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign add_a  = op_q.a;
    assign add_b  = op_q.b;
    assign add_op = op_q.op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= add_sum;
            rsp_id    <= id_q;
        end else if (release_rsp) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
    logic flag_v;

    // Overflow judged on the held operands: subtract flips the sign sense of B.
    always_comb begin
        flag_v = (add_op ? (add_a[WIDTH-1] != add_b[WIDTH-1])
                         : (add_a[WIDTH-1] == add_b[WIDTH-1]))
                 && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_flags <= 4'b0;
        end else if (capture) begin
            rsp_flags <= {add_cout, (add_sum == '0), add_sum[WIDTH-1], flag_v};
        end
    end
`else
    logic unused_cout;
    assign unused_cout = add_cout;
`endif

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Randomized and directed bench for addsub_share_ctrl with a combinational adder model as the shared datapath.
module tb_addsub_share_ctrl;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req0_ready, req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_op, add_cout, busy;
    logic [W:0]   full;
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
    logic [3:0]   rsp_flags;
    logic [3:0]   got_flags;
`endif

    always #5 clk = ~clk;

    assign full     = {1'b0, add_a} + {1'b0, add_b ^ {W{add_op}}} + {{W{1'b0}}, add_op};
    assign add_sum  = full[W-1:0];
    assign add_cout = full[W];

    addsub_share_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy)
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
        , .rsp_flags(rsp_flags)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int r;
        r = op ? int'(a) - int'(b) : int'(a) + int'(b);
        return r[W-1:0];
    endfunction

`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
    function automatic logic [3:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int ua, ub, sa, sb, ur, sr;
        logic [W-1:0] res;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        ur = op ? ua - ub : ua + ub;
        sr = op ? sa - sb : sa + sb;
        c  = op ? (ua >= ub) : (ur >= 2**W);
        v  = (sr >= 2**(W-1)) || (sr < -(2**(W-1)));
        res = ur[W-1:0];
        return {c, (res == '0), res[W-1], v};
    endfunction
`endif

    // Reference model: one operation in flight, tie broken against whoever was served last.
    logic         busy_m = 1'b0;
    logic         last_id = 1'b1;
    logic         m_id, m_op, e0, e1, resp_m;
    logic [W-1:0] m_a, m_b;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           acc_ids[$];
    int           acc_cycs[$];
    logic         acc_pulse = 1'b0;
    logic         acc_pulse_id = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            acc_pulse = 1'b0;
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_rdy", {req0_ready, req1_ready}, 0);
                chk("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
                chk("rst_add", {add_op, add_a, add_b}, 0);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
                chk("rst_flags", rsp_flags, 0);
`endif
                busy_m  = 1'b0;
                last_id = 1'b1;
            end else begin
                cyc++;
                e0 = !busy_m && req0_valid && (!req1_valid || last_id);
                e1 = !busy_m && req1_valid && (!req0_valid || !last_id);
                chk("busy", busy, busy_m);
                chk("rdy0", req0_ready, e0);
                chk("rdy1", req1_ready, e1);
                if (busy_m) begin
                    chk("add_a", add_a, m_a);
                    chk("add_b", add_b, m_b);
                    chk("add_op", add_op, m_op);
                    resp_m = (cyc - acc_cyc) > S;
                    chk("rsp_valid", rsp_valid, resp_m);
                    if (resp_m) begin
                        chk("rsp_data", rsp_data, ref_sum(m_a, m_b, m_op));
                        chk("rsp_id", rsp_id, m_id);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
                        chk("rsp_flags", rsp_flags, ref_flags(m_a, m_b, m_op));
`endif
                        if (rsp_ready) busy_m = 1'b0;
                    end
                end else begin
                    chk("rsp_valid_idle", rsp_valid, 0);
                end
                if (e0 || e1) begin
                    m_id    = e1;
                    m_a     = e1 ? req1_a : req0_a;
                    m_b     = e1 ? req1_b : req0_b;
                    m_op    = e1 ? req1_op : req0_op;
                    busy_m  = 1'b1;
                    last_id = m_id;
                    acc_cyc = cyc;
                    acc_ids.push_back(int'(m_id));
                    acc_cycs.push_back(cyc);
                    acc_pulse    = 1'b1;
                    acc_pulse_id = m_id;
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic ok;
        ok = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) ok = 1'b1;
        end
        if (!ok) chk("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [W-1:0] d, output logic id);
        logic ok;
        ok = 1'b0;
        d  = '0;
        id = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                d  = rsp_data;
                id = rsp_id;
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
                got_flags = rsp_flags;
`endif
                ok = 1'b1;
            end
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        for (int i = 0; i < 100 && acc_ids.size() == 0; i++) @(posedge clk);
        #1;
        if (acc_ids.size() == 0) begin
            chk("acc_timeout", 0, 1);
            acc_ids.push_back(-1);
        end
    endtask

    task automatic rand_ops(input logic id);
        if (id) begin
            req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 1'($urandom);
        end else begin
            req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 1'($urandom);
        end
    endtask

    logic [W-1:0] d;
    logic         id;

    initial begin
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready  = 0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;

        issue(1'b0, 8'h25, 8'h13, 1'b0);
        wait_rsp(d, id);
        chk("t1_data", d, 8'h38);
        chk("t1_id", id, 0);

        issue(1'b1, 8'h10, 8'h20, 1'b1);
        wait_rsp(d, id);
        chk("t2_data", d, 8'hF0);
        chk("t2_id", id, 1);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
        chk("t2_flags", got_flags, 4'b0010);
`endif

        acc_ids.delete();
        acc_cycs.delete();
        rand_ops(1'b0);
        rand_ops(1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (42) begin
            @(posedge clk);
            #1;
            if (acc_pulse) rand_ops(acc_pulse_id);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        chk("t3_count", (acc_ids.size() >= 8), 1);
        for (int i = 0; i < 8 && i < acc_ids.size(); i++) begin
            chk("t3_alt", acc_ids[i], i % 2);
            if (i > 0) chk("t3_period", acc_cycs[i] - acc_cycs[i-1], S + 2);
        end

        rsp_ready = 1'b0;
        issue(1'b0, 8'h5A, 8'h33, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("t4_valid", rsp_valid, 1);
        repeat (6) @(negedge clk);
        chk("t4_hold_data", rsp_data, 8'h8D);
        chk("t4_hold_id", rsp_id, 0);
        chk("t4_hold_add", {add_a, add_b}, 16'h5A33);
        chk("t4_rdy", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        acc_ids.delete();
        rsp_ready = 1'b1;
        wait_acc();
        chk("t4_next", acc_ids[0], 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        issue(1'b1, 8'h44, 8'h11, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_rsp", {rsp_valid, rsp_data}, 0);
        chk("t5_add", {add_op, add_a, add_b}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc_ids.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_acc();
        chk("t5_next", acc_ids[0], 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        issue(1'b0, 8'h7F, 8'h01, 1'b0);
        wait_rsp(d, id);
        chk("t6a_data", d, 8'h80);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
        chk("t6a_flags", got_flags, 4'b0011);
`endif
        issue(1'b0, 8'h80, 8'h01, 1'b1);
        wait_rsp(d, id);
        chk("t6b_data", d, 8'h7F);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
        chk("t6b_flags", got_flags, 4'b1001);
`endif
        issue(1'b0, 8'h05, 8'h05, 1'b1);
        wait_rsp(d, id);
        chk("t6c_data", d, 8'h00);
`ifdef ADDSUB_SHARE_CTRL_FLAGS_EN
        chk("t6c_flags", got_flags, 4'b1100);
`endif

        repeat (400) begin
            @(posedge clk);
            #1;
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            rand_ops(1'b0);
            rand_ops(1'b1);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
